ram_port_arbiter: RTL
=====================

Name: ram_port_arbiter

Overview:
- Shares the single-port SoC data RAM between two requesters: the CPU load/store port and the UART transfer engine.
- Each requester uses a req/gnt handshake. Reads return one cycle after grant.
- Arbitration is owner-sticky with round-robin tie-break, a burst limit for fairness, and a bounded lock for atomic sequences.
- Sits between the CPU/UART and the RAM macro. The arbiter is the only driver of the RAM address/we/wdata.

Parameters:
- MAXBURST, 16: consecutive grants the current owner may take while the other requester waits.
- LOCKMAX, 64: maximum consecutive locked grants before the lock is ignored.
- IDLE_ADDR, 411699: RAM address driven when no grant (UART status word).

Ports:
- clk  in  1  clock
- nrst  in  1  asynchronous, active-low reset
- cpu_req, uart_req  in  1  access request, held until gnt
- cpu_we, uart_we  in  1  1=write, 0=read
- cpu_lock, uart_lock  in  1  request to keep ownership next cycle
- cpu_addr, uart_addr  in  32  word address
- cpu_wdata, uart_wdata  in  32  write data
- cpu_gnt, uart_gnt  out  1  combinational grant; access is performed this cycle
- cpu_rvalid, uart_rvalid  out  1  registered; read data valid
- cpu_rdata, uart_rdata  out  32  ram_rdata passthrough to both ports
- ram_addr  out  32  RAM address
- ram_we  out  1  RAM write enable
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM sync read data, 1-cycle latency
- lock_err  out  1  sticky flag: a lock timed out

Behaviour:
- Registered state:
  - owner {NONE, CPU, UART}
  - rr_last {CPU, UART}
  - burstcnt[7:0]
  - lockcnt[7:0]
  - lock_err
  - rvalid flops
- Reset values: owner=NONE, rr_last=UART (so CPU wins the first tie), counters=0, lock_err=0, both rvalid=0.
- While nrst is low, both gnt=0 and ram_we=0.
- Grant decision is combinational each cycle, evaluated in priority order:
  1. Owner X with X_req & X_lock & lockcnt<LOCKMAX -> grant X.
  2. Both requesting and owner X with burstcnt<MAXBURST -> grant X.
  3. Both requesting, otherwise -> grant the requester that is not rr_last.
  4. Single requester -> grant it.
  5. No requests -> no grant.
- At most one gnt per cycle (one-hot or zero).
- RAM mux:
  - When granted: ram_addr/ram_we/ram_wdata = the granted requester's signals.
  - When not granted: ram_addr=IDLE_ADDR, ram_we=0, ram_wdata=0.
- State update on posedge:
  - Grant to the same requester as owner: burstcnt saturating +1.
  - Grant to a different requester: owner=new, burstcnt=1.
  - Any grant: rr_last=granted requester.
  - No grant: owner=NONE, burstcnt=0, rr_last unchanged.
- Lock counter:
  - lockcnt +1 (saturating) when the granted requester has lock=1.
  - lockcnt=0 when lock=0 or the grant changes.
  - When lockcnt==LOCKMAX and the owner still asserts lock: lock is ignored (rules 2–5 apply) and lock_err<=1.
  - lock_err stays set until reset.
- Read return: X_rvalid <= X_gnt & ~X_we. rdata is valid only while rvalid=1.
- Simultaneous events:
  - A lock by the non-owner has no effect until that requester holds ownership.
  - Owner dropping req while the other requests: the other is granted the same cycle, burstcnt=1.
- Reset mid-operation: any pending rvalid is dropped. No write is issued in the reset cycle.
- Requesters must hold addr/we/wdata stable while req=1 and gnt=0.

Decomposition:
- Shared package soc_pkg:
  - owner_t enum {NONE, CPU, UART}
  - memory map constants: IMG_BASE=206800, UART_EXC_ADDR=411698, UART_CTRL_ADDR=411699
- No sub-module is required. Arbitration and counters fit in one always_comb and one always_ff.

Test Plan:
1. Only CPU reads 0x10, 0x11 back-to-back -> cpu_gnt=1 both cycles; cpu_rvalid=1 on each following cycle with RAM contents; uart_gnt=0 throughout.
2. CPU and UART both request from reset in the same cycle -> CPU granted first, then CPU keeps the grant for 16 cycles total, then UART granted at cycle 17 with burstcnt=1.
3. UART owns with uart_lock=1 and CPU requesting -> UART granted for 64 consecutive cycles; on the 65th cycle CPU is granted and lock_err=1 stays high until nrst.
4. UART writes 0x00000001 to 411698 while CPU is idle -> ram_we=1, ram_addr=411698, ram_wdata=1 in the grant cycle; next idle cycle ram_addr=411699, ram_we=0.
5. CPU read granted, nrst pulsed low before the next edge -> cpu_rvalid=0 after reset; owner=NONE; the next tie goes to CPU.
6. Owner CPU drops req while UART holds req -> uart_gnt=1 in the same cycle; no cycle in which both gnt are high.

Source files
------------

// File: rtl/soc_pkg.sv
// +--------------------------------------------------------------------------+
// | Module      : soc_pkg                                                    |
// | Description : Shared SoC types and memory-map constants used by the RAM  |
// |               port arbiter and its neighbours.                           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

package soc_pkg;

  // Current holder of the data RAM port; NONE means the port is idle.
  typedef enum logic [1:0] {
    NONE = 2'd0,
    CPU  = 2'd1,
    UART = 2'd2
  } owner_t;

  // Data RAM memory map (word addresses).
  localparam logic [31:0] IMG_BASE       = 32'd206800;
  localparam logic [31:0] UART_EXC_ADDR  = 32'd411698;
  localparam logic [31:0] UART_CTRL_ADDR = 32'd411699;

  // Increment an 8-bit counter, holding at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_port_arbiter.sv
// +--------------------------------------------------------------------------+
// | Module      : ram_port_arbiter                                           |
// | Description : Shares the single-port data RAM between the CPU load/store |
// |               port and the UART transfer engine. Owner-sticky grants     |
// |               with round-robin tie-break, a burst limit for fairness and |
// |               a bounded lock for atomic sequences.                       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module ram_port_arbiter
  import soc_pkg::*;
#(
  parameter int unsigned MAXBURST  = 16,
  parameter int unsigned LOCKMAX   = 64,
  parameter logic [31:0] IDLE_ADDR = UART_CTRL_ADDR
) (
  input  logic        clk,
  input  logic        nrst,

  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic        cpu_lock,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,

  input  logic        uart_req,
  input  logic        uart_we,
  input  logic        uart_lock,
  input  logic [31:0] uart_addr,
  input  logic [31:0] uart_wdata,
  output logic        uart_gnt,
  output logic        uart_rvalid,
  output logic [31:0] uart_rdata,

  output logic [31:0] ram_addr,
  output logic        ram_we,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata,

  output logic        lock_err
);

  // Limits narrowed to the counter width; both counters saturate at 255,
  // so limits above that are not meaningful.
  localparam logic [7:0] c_max_burst = 8'(MAXBURST);
  localparam logic [7:0] c_lock_max  = 8'(LOCKMAX);

  // Arbitration state
  owner_t      r_owner;
  owner_t      r_rr_last;
  logic [7:0]  r_burstcnt;
  logic [7:0]  r_lockcnt;
  logic        r_lock_err;
  logic        r_cpu_rvalid;
  logic        r_uart_rvalid;

  // Combinational decision signals
  owner_t      w_grant;
  logic        w_cpu_locked;
  logic        w_uart_locked;
  logic        w_lock_live;
  logic        w_lock_expired;
  logic        w_grant_lock;

  // Decide whether the current owner is asking to keep the port and whether
  // its lock budget still allows that. A lock from the non-owner is ignored.
  always_comb begin
    w_cpu_locked   = (r_owner == CPU)  && cpu_req  && cpu_lock;
    w_uart_locked  = (r_owner == UART) && uart_req && uart_lock;
    w_lock_live    = (r_lockcnt < c_lock_max);
    w_lock_expired = (w_cpu_locked || w_uart_locked) && !w_lock_live;
  end

  // Grant selection in priority order: live lock, sticky owner within its
  // burst budget, round-robin on a tie, lone requester, otherwise idle.
  // Nothing is granted while reset is asserted.
  always_comb begin
    w_grant = NONE;
    if (!nrst) begin
      w_grant = NONE;
    end else if (w_cpu_locked && w_lock_live) begin
      w_grant = CPU;
    end else if (w_uart_locked && w_lock_live) begin
      w_grant = UART;
    end else if (cpu_req && uart_req) begin
      if ((r_owner != NONE) && (r_burstcnt < c_max_burst)) begin
        w_grant = r_owner;
      end else if (r_rr_last == CPU) begin
        w_grant = UART;
      end else begin
        w_grant = CPU;
      end
    end else if (cpu_req) begin
      w_grant = CPU;
    end else if (uart_req) begin
      w_grant = UART;
    end
  end

  // Route the granted requester onto the RAM; park on the UART status word
  // with writes disabled when the port is idle.
  always_comb begin
    ram_addr     = IDLE_ADDR;
    ram_we       = 1'b0;
    ram_wdata    = '0;
    w_grant_lock = 1'b0;
    unique case (w_grant)
      CPU: begin
        ram_addr     = cpu_addr;
        ram_we       = cpu_we;
        ram_wdata    = cpu_wdata;
        w_grant_lock = cpu_lock;
      end
      UART: begin
        ram_addr     = uart_addr;
        ram_we       = uart_we;
        ram_wdata    = uart_wdata;
        w_grant_lock = uart_lock;
      end
      default: ;
    endcase
  end

  assign cpu_gnt  = (w_grant == CPU);
  assign uart_gnt = (w_grant == UART);

  // Track ownership, burst length and locked-grant streak after each cycle;
  // a change of holder restarts both counters from this grant.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_owner    <= NONE;
      r_rr_last  <= UART;
      r_burstcnt <= '0;
      r_lockcnt  <= '0;
      r_lock_err <= 1'b0;
    end else begin
      if (w_grant == NONE) begin
        r_owner    <= NONE;
        r_burstcnt <= '0;
        r_lockcnt  <= '0;
      end else begin
        r_owner    <= w_grant;
        r_rr_last  <= w_grant;
        r_burstcnt <= (w_grant == r_owner) ? sat_inc8(r_burstcnt) : 8'd1;
        if (!w_grant_lock) begin
          r_lockcnt <= '0;
        end else if (w_grant == r_owner) begin
          r_lockcnt <= sat_inc8(r_lockcnt);
        end else begin
          r_lockcnt <= 8'd1;
        end
      end
      if (w_lock_expired) begin
        r_lock_err <= 1'b1;
      end
    end
  end

  // Flag read data one cycle after a granted read, matching the RAM latency.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_cpu_rvalid  <= 1'b0;
      r_uart_rvalid <= 1'b0;
    end else begin
      r_cpu_rvalid  <= cpu_gnt  & ~cpu_we;
      r_uart_rvalid <= uart_gnt & ~uart_we;
    end
  end

  assign cpu_rvalid  = r_cpu_rvalid;
  assign uart_rvalid = r_uart_rvalid;
  assign cpu_rdata   = ram_rdata;
  assign uart_rdata  = ram_rdata;
  assign lock_err    = r_lock_err;

endmodule

`default_nettype wire
